// File: rtl/spram_pkg.sv
// Shared constants and power-state type for the SPRAM behavioural model.
// Imported by spram_nibble_merge and sb_spram256ka_model.
package spram_pkg;

    localparam int SPRAM_ADDR_W  = 14;
    localparam int SPRAM_DATA_W  = 16;
    localparam int SPRAM_DEPTH   = 16384;
    localparam int SPRAM_NIBBLES = 4;

    typedef enum logic [1:0] {
        ACTIVE,
        STANDBY,
        SLEEP,
        OFF
    } pwr_state_e;

endpackage

// File: rtl/spram_nibble_merge.sv
// Combinational nibble merge: each nibble of merged_word comes from new_word
// where mask bit is set, else from old_word. Ports: old_word, new_word, mask, merged_word.
module spram_nibble_merge
    import spram_pkg::*;
(
    input  logic [SPRAM_DATA_W-1:0]  old_word,
    input  logic [SPRAM_DATA_W-1:0]  new_word,
    input  logic [SPRAM_NIBBLES-1:0] mask,
    output logic [SPRAM_DATA_W-1:0]  merged_word
);

    always_comb begin
        merged_word = old_word;
        for (int n = 0; n < SPRAM_NIBBLES; n++) begin
            if (mask[n]) begin
                merged_word[4*n +: 4] = new_word[4*n +: 4];
            end
        end
    end

endmodule

// File: rtl/sb_spram256ka_model.sv
// iCE40UP SPRAM256KA model: 16K x 16 RAM, nibble-masked write, 1-cycle
// registered read, standby/sleep/power-off controls, sync active-high RESET.
// Ports: CLOCK, RESET, ADDRESS, DATAIN, MASKWREN, WREN, CHIPSELECT,
// STANDBY, SLEEP, POWEROFF (active-low), DATAOUT.
// Macro SPRAM_POWERLOSS_X_EN: power loss fills with X, blocked accesses warn.
module sb_spram256ka_model #(
    parameter int          ADDR_W     = spram_pkg::SPRAM_ADDR_W,
    parameter int          DATA_W     = spram_pkg::SPRAM_DATA_W,
    parameter int          DEPTH      = spram_pkg::SPRAM_DEPTH,
    parameter logic [15:0] INIT_VALUE = 16'h0000
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [DATA_W-1:0] DATAIN,
    input  logic [3:0]        MASKWREN,
    input  logic              WREN,
    input  logic              CHIPSELECT,
    input  logic              STANDBY,
    input  logic              SLEEP,
    input  logic              POWEROFF,
    output logic [DATA_W-1:0] DATAOUT
);

    // Port names STANDBY/SLEEP shadow the enum labels; those are qualified.
    import spram_pkg::*;

`ifdef SPRAM_POWERLOSS_X_EN
    localparam logic [DATA_W-1:0] LOSS_VALUE = 'x;
`else
    localparam logic [DATA_W-1:0] LOSS_VALUE = INIT_VALUE;
`endif

    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: INIT_VALUE};
    logic [DATA_W-1:0] dout_q = '0;
    logic [DATA_W-1:0] dout_d;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] wr_word;
    logic              wr_en;
    pwr_state_e        pstate;

    always_comb begin
        pstate = ACTIVE;
        if (!POWEROFF) begin
            pstate = OFF;
        end else if (SLEEP) begin
            pstate = spram_pkg::SLEEP;
        end else if (STANDBY) begin
            pstate = spram_pkg::STANDBY;
        end
    end

    assign rd_word = mem_q[ADDRESS];

    spram_nibble_merge u_merge (
        .old_word    (rd_word),
        .new_word    (DATAIN),
        .mask        (MASKWREN),
        .merged_word (wr_word)
    );

    always_comb begin
        wr_en  = !RESET && (pstate == ACTIVE) && CHIPSELECT && WREN;
        dout_d = dout_q;
        case (pstate)
            OFF:               dout_d = '0;
            spram_pkg::SLEEP:  dout_d = '0;
            ACTIVE: begin
                if (CHIPSELECT && !WREN) begin
                    dout_d = rd_word;
                end
            end
            default:           dout_d = dout_q;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    // Contents vanish with power regardless of RESET.
    always_ff @(posedge CLOCK) begin
        if (!POWEROFF) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i[ADDR_W-1:0]] <= LOSS_VALUE;
            end
        end else if (wr_en) begin
            mem_q[ADDRESS] <= wr_word;
        end
    end

`ifdef SPRAM_POWERLOSS_X_EN
    always_ff @(posedge CLOCK) begin
        if (!RESET && CHIPSELECT && (pstate != ACTIVE)) begin
            $display("spram warning: access at %0t addr %h in %s",
                     $time, ADDRESS, pstate.name());
        end
    end
`endif

    assign DATAOUT = dout_q;

endmodule

// File: tb/tb_sb_spram256ka_model.sv
// Directed bench for sb_spram256ka_model with a word-level reference model
// compared on every falling edge, plus hand-computed literal checks.
module tb_sb_spram256ka_model;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [13:0] addr = '0;
    logic [15:0] din = '0;
    logic [3:0]  mask = '0;
    logic        we = 1'b0;
    logic        cs = 1'b0;
    logic        stby = 1'b0;
    logic        slp = 1'b0;
    logic        pwr = 1'b1;
    logic [15:0] dout;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

`ifdef SPRAM_POWERLOSS_X_EN
    logic [15:0] loss_fill = 16'h0000;
`endif
    logic [15:0] fill = 16'h0000;
    logic [15:0] mdl [int];
    logic [15:0] m_dout = 16'h0000;

    sb_spram256ka_model dut (
        .CLOCK      (clk),
        .RESET      (rst),
        .ADDRESS    (addr),
        .DATAIN     (din),
        .MASKWREN   (mask),
        .WREN       (we),
        .CHIPSELECT (cs),
        .STANDBY    (stby),
        .SLEEP      (slp),
        .POWEROFF   (pwr),
        .DATAOUT    (dout)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mget(input int a);
        if (mdl.exists(a)) return mdl[a];
        return fill;
    endfunction

    // Reference: memory as a sparse word map, output as one variable.
    always @(posedge clk) begin
        logic [15:0] w;
        if (!pwr) begin
            mdl.delete();
`ifdef SPRAM_POWERLOSS_X_EN
            fill = 16'hxxxx;
`endif
        end
        if (rst || !pwr || slp) begin
            if (rst || !pwr || slp) m_dout = 16'h0000;
        end else if (stby || !cs) begin
        end else if (we) begin
            w = mget(int'(addr));
            for (int n = 0; n < 4; n++)
                if (mask[n]) w[4*n +: 4] = din[4*n +: 4];
            mdl[int'(addr)] = w;
        end else begin
            m_dout = mget(int'(addr));
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (dout !== m_dout) begin
                miscompares++;
                $display("FAIL model t=%0t got %h want %h", $time, dout, m_dout);
            end
        end
    end

    task automatic step(input bit r, p, s, sb, c, w,
                        input logic [3:0] m, input logic [13:0] a,
                        input logic [15:0] d);
        rst = r; pwr = p; slp = s; stby = sb; cs = c; we = w;
        mask = m; addr = a; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [13:0] a, input logic [15:0] d,
                      input logic [3:0] m);
        step(0, 1, 0, 0, 1, 1, m, a, d);
    endtask

    task automatic rd(input logic [13:0] a);
        step(0, 1, 0, 0, 1, 0, 4'hF, a, 16'h0);
    endtask

    task automatic lit(input string name, input logic [15:0] exp);
        vectors++;
        if (dout !== exp) begin
            miscompares++;
            $display("FAIL %s got %h want %h", name, dout, exp);
        end
    endtask

    initial begin
        #1;
        lit("time0", 16'h0000);
        @(negedge clk);
        chk_en = 1'b1;

        wr(14'd5, 16'hBEEF, 4'hF);
        rd(14'd5);
        lit("rd5", 16'hBEEF);
        step(1, 1, 0, 0, 1, 0, 4'h0, 14'd5, 16'h0);
        lit("reset", 16'h0000);
        rd(14'd5);
        lit("rd5_after_rst", 16'hBEEF);

        wr(14'd3, 16'h1234, 4'hF);
        lit("wr_holds", 16'hBEEF);
        rd(14'd3);
        lit("rd3", 16'h1234);

        wr(14'h10, 16'hAAAA, 4'hF);
        wr(14'h10, 16'h5555, 4'b0101);
        rd(14'h10);
        lit("mask0101", 16'hA5A5);
        wr(14'h10, 16'hFFFF, 4'b0000);
        rd(14'h10);
        lit("mask0000", 16'hA5A5);

        wr(14'h0000, 16'h0001, 4'hF);
        wr(14'h3FFF, 16'hFFFE, 4'hF);
        rd(14'h0000);
        lit("addr_lo", 16'h0001);
        rd(14'h3FFF);
        lit("addr_hi", 16'hFFFE);
        rd(14'd3);
        lit("b2b", 16'h1234);

        rd(14'h0000);
        step(0, 1, 0, 1, 1, 0, 4'h0, 14'h3FFF, 16'h0);
        lit("standby", 16'h0001);

        step(0, 1, 1, 0, 1, 0, 4'h0, 14'd3, 16'h0);
        lit("sleep", 16'h0000);
        step(0, 1, 1, 0, 1, 1, 4'hF, 14'd3, 16'h0000);
        rd(14'd3);
        lit("wake", 16'h1234);

        step(1, 1, 0, 0, 1, 1, 4'hF, 14'h20, 16'hDEAD);
        lit("rst_wr", 16'h0000);
        rd(14'h20);
        lit("rst_blocked", 16'h0000);

        step(0, 1, 0, 0, 0, 1, 4'hF, 14'd3, 16'hFFFF);
        rd(14'd3);
        lit("cs0", 16'h1234);

        for (int i = 0; i < 12; i++)
            wr(14'(i * 1371 + 7), 16'(i * 16'h1357 + 16'h0F0F), 4'(i + 3));
        for (int i = 0; i < 12; i++)
            rd(14'(i * 1371 + 7));

        step(0, 0, 0, 0, 1, 0, 4'h0, 14'd3, 16'h0);
        lit("pwroff", 16'h0000);
        rd(14'd3);
`ifdef SPRAM_POWERLOSS_X_EN
        lit("pwr_loss", 16'hxxxx);
`else
        lit("pwr_loss", 16'h0000);
`endif
        rd(14'd5);
        wr(14'd5, 16'h00C0, 4'b0010);
        rd(14'd5);

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
